// File: rtl/alu_seq.sv
// alu_seq: sequential ALU.
//   Ops 0-12 (add/sub/logic/shift/rotate) complete in one cycle.
//   MUL (shift-add) and DIVU/REMU (restoring division) iterate one bit per
//   cycle for WIDTH cycles.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request; op/a/b/carry_in sampled when start && !busy
//   op[3:0]           operation code
//   a, b [WIDTH-1:0]  operands
//   carry_in          carry for ADC/SBB/RCL
//   busy              multi-cycle op in progress
//   done              one-cycle pulse, outputs valid
//   result, result_hi primary result / MUL high half or remainder
//   flags_out[3:0]    {V,S,C,Z}
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags_out
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_ADC = 4'd2,  OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8,  OP_SAR = 4'd9,  OP_ROL = 4'd10, OP_ROR = 4'd11;
  localparam logic [3:0] OP_RCL = 4'd12, OP_MUL = 4'd13, OP_DIVU = 4'd14, OP_REMU = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state, w_state_nxt;
  logic [SH_W-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_b;
  logic [3:0]         r_op;
  logic               r_done;
  logic [WIDTH-1:0]   r_result, r_result_hi;
  logic [3:0]         r_flags;

  logic               w_accept, w_last;
  assign w_accept = start && (r_state == S_IDLE);
  assign w_last   = (r_cnt == SH_W'(WIDTH - 1));

  // ---------------- single-cycle datapath ----------------
  logic [SH_W-1:0]  w_n;
  logic [SH_W:0]    w_rot_back, w_rcl_back;
  logic             w_cin_add, w_bin;
  logic [WIDTH:0]   w_sum, w_diff, w_shl, w_shr, w_rcl_v, w_rcl;
  logic signed [WIDTH:0] w_sar;
  logic [WIDTH-1:0] w_rol, w_ror;

  assign w_n        = b[SH_W-1:0];
  assign w_rot_back = (SH_W+1)'(WIDTH) - {1'b0, w_n};
  assign w_rcl_back = (SH_W+1)'(WIDTH + 1) - {1'b0, w_n};
  assign w_cin_add  = (op == OP_ADC) && carry_in;
  assign w_bin      = (op == OP_SBB) && carry_in;
  assign w_sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin_add};
  // Bit WIDTH of the difference is the borrow (a < b + borrow-in).
  assign w_diff     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_bin};
  // Extra bit on the shifted-out side captures the last bit shifted out.
  assign w_shl      = {1'b0, a} << w_n;
  assign w_shr      = {a, 1'b0} >> w_n;
  assign w_sar      = $signed({a, 1'b0}) >>> w_n;
  assign w_rol      = (a << w_n) | (a >> w_rot_back);
  assign w_ror      = (a >> w_n) | (a << w_rot_back);
  assign w_rcl_v    = {carry_in, a};
  assign w_rcl      = (w_rcl_v << w_n) | (w_rcl_v >> w_rcl_back);

  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SAR: begin
        w_res = w_sar[WIDTH:1];
        w_c   = w_sar[0];
      end
      OP_ROL: begin
        w_res = w_rol;
        w_c   = (w_n != '0) && w_rol[0];
      end
      OP_ROR: begin
        w_res = w_ror;
        w_c   = (w_n != '0) && w_ror[WIDTH-1];
      end
      OP_RCL: begin
        w_res = w_rcl[WIDTH-1:0];
        w_c   = w_rcl[WIDTH];
      end
      default: ;
    endcase
  end

  // ---------------- iterative datapath ----------------
  // Multiply: {r_hi,r_lo} shifts right, adding the multiplicand into r_hi
  // whenever the multiplier LSB (r_lo[0]) is set.
  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mul_hi_nxt, w_mul_lo_nxt;
  assign w_madd       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mul_hi_nxt = w_madd[WIDTH:1];
  assign w_mul_lo_nxt = {w_madd[0], r_lo[WIDTH-1:1]};

  // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out the
  // top and quotient bits in the bottom. A zero divisor always "fits", which
  // yields an all-ones quotient and remainder = a without special casing.
  logic [WIDTH:0]   w_dshift;
  logic             w_dok;
  logic [WIDTH-1:0] w_div_rem_nxt, w_div_q_nxt;
  assign w_dshift      = {r_hi, r_lo[WIDTH-1]};
  assign w_dok         = (w_dshift >= {1'b0, r_b});
  assign w_div_rem_nxt = w_dok ? (w_dshift[WIDTH-1:0] - r_b) : w_dshift[WIDTH-1:0];
  assign w_div_q_nxt   = {r_lo[WIDTH-2:0], w_dok};

  logic [WIDTH-1:0] w_fin_res, w_fin_hi;
  logic             w_fin_c, w_fin_v;

  always_comb begin
    w_fin_res = '0;
    w_fin_hi  = '0;
    w_fin_c   = 1'b0;
    w_fin_v   = 1'b0;
    if (r_state == S_MUL) begin
      w_fin_res = w_mul_lo_nxt;
      w_fin_hi  = w_mul_hi_nxt;
      w_fin_c   = (w_mul_hi_nxt != '0);
      w_fin_v   = (w_mul_hi_nxt != '0);
    end else begin
      w_fin_res = (r_op == OP_DIVU) ? w_div_q_nxt : w_div_rem_nxt;
      w_fin_hi  = w_div_rem_nxt;
      w_fin_v   = (r_b == '0);
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (op == OP_MUL)                         w_state_nxt = S_MUL;
          else if (op == OP_DIVU || op == OP_REMU)  w_state_nxt = S_DIV;
        end
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = r_done;
    result    = r_result;
    result_hi = r_result_hi;
    flags_out = r_flags;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (op < OP_MUL) begin
          r_result    <= w_res;
          r_result_hi <= '0;
          r_flags     <= {w_v, w_res[WIDTH-1], w_c, (w_res == '0)};
          r_done      <= 1'b1;
        end else begin
          r_hi  <= '0;
          r_lo  <= a;
          r_b   <= b;
          r_op  <= op;
          r_cnt <= '0;
        end
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_state == S_MUL) begin
          r_hi <= w_mul_hi_nxt;
          r_lo <= w_mul_lo_nxt;
        end else begin
          r_hi <= w_div_rem_nxt;
          r_lo <= w_div_q_nxt;
        end
        if (w_last) begin
          r_result    <= w_fin_res;
          r_result_hi <= w_fin_hi;
          r_flags     <= {w_fin_v, w_fin_res[WIDTH-1], w_fin_c, (w_fin_res == '0)};
          r_done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=16): scoreboard of expected results pushed
// when a request is driven and popped when done is observed.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         carry_in;
  logic         busy, done;
  logic [W-1:0] result, result_hi;
  logic [3:0]   flags_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   fl;
    int           lat;
  } exp_t;

  exp_t exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .carry_in(carry_in), .busy(busy), .done(done), .result(result),
    .result_hi(result_hi), .flags_out(flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [W-1:0] r, logic [W-1:0] h, logic [3:0] f, int l);
    exp_t e;
    e.res = r; e.hi = h; e.fl = f; e.lat = l;
    return e;
  endfunction

  // Behavioural reference: bit-serial loops for shifts, native * / % for MUL/DIV.
  function automatic exp_t model(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y, logic ci);
    exp_t e;
    logic [31:0] t;
    logic [W-1:0] r, h;
    logic c, v, nc;
    int n;
    n = int'(y[3:0]);
    r = '0; h = '0; c = 1'b0; v = 1'b0;
    case (o)
      4'd0, 4'd2: begin
        t = {16'd0, x} + {16'd0, y} + ((o == 4'd2) ? 32'(ci) : 32'd0);
        r = t[W-1:0]; c = t[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'd1, 4'd3: begin
        t = (o == 4'd3) ? 32'(ci) : 32'd0;
        r = x - y - t[W-1:0];
        c = ({16'd0, x} < ({16'd0, y} + t));
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'd4: r = x & y;
      4'd5: r = x | y;
      4'd6: r = x ^ y;
      4'd7: begin r = x; for (int i = 0; i < n; i++) begin c = r[W-1]; r = r << 1; end end
      4'd8: begin r = x; for (int i = 0; i < n; i++) begin c = r[0]; r = r >> 1; end end
      4'd9: begin r = x; for (int i = 0; i < n; i++) begin c = r[0]; r = {r[W-1], r[W-1:1]}; end end
      4'd10: begin r = x; for (int i = 0; i < n; i++) begin r = {r[W-2:0], r[W-1]}; c = r[0]; end end
      4'd11: begin r = x; for (int i = 0; i < n; i++) begin r = {r[0], r[W-1:1]}; c = r[W-1]; end end
      4'd12: begin
        r = x; c = ci;
        for (int i = 0; i < n; i++) begin nc = r[W-1]; r = {r[W-2:0], c}; c = nc; end
      end
      4'd13: begin
        t = {16'd0, x} * {16'd0, y};
        r = t[W-1:0]; h = t[31:16]; c = (h != 0); v = c;
      end
      default: begin
        if (y == 0) begin
          h = x; v = 1'b1; r = (o == 4'd14) ? {W{1'b1}} : x;
        end else begin
          h = x % y; r = (o == 4'd14) ? (x / y) : h;
        end
      end
    endcase
    return mk(r, h, {v, r[W-1], c, (r == 0)}, (o >= 4'd13) ? W + 1 : 1);
  endfunction

  // Called on a falling edge; returns on the next falling edge with start low.
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input exp_t e);
    exp_q.push_back(e);
    op = o; a = x; b = y; carry_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; optionally hammers the inputs while busy.
  task automatic collect(input string name, input bit disturb);
    exp_t e;
    int lat;
    bit busy_ok;
    lat = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        op = 4'($urandom_range(0, 12));
        a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done not seen after %0d cycles", name, lat);
      return;
    end
    checks++;
    if (result !== e.res) begin errors++; $display("FAIL %s result: got %h expected %h", name, result, e.res); end
    checks++;
    if (result_hi !== e.hi) begin errors++; $display("FAIL %s result_hi: got %h expected %h", name, result_hi, e.hi); end
    checks++;
    if (flags_out !== e.fl) begin errors++; $display("FAIL %s flags: got %b expected %b", name, flags_out, e.fl); end
    checks++;
    if (lat != e.lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy at done: got %b expected 0", name, busy); end
    if (e.lat > 1) begin
      checks++;
      if (!busy_ok) begin errors++; $display("FAIL %s busy during op: got 0 expected 1", name); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0001; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset busy/done: got %b expected 00", {busy, done}); end
    checks++;
    if ({result, result_hi, flags_out} !== 36'd0) begin
      errors++; $display("FAIL reset outputs: got %h/%h/%b expected zeros", result, result_hi, flags_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset start-priority done: got %b expected 0", done); end
  endtask

  task automatic test_arith;
    send(4'd0, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 16'h0, 4'b1100, 1)); collect("add_ovf", 0);
    send(4'd1, 16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 16'h0, 4'b0110, 1)); collect("sub_borrow", 0);
    send(4'd3, 16'h0005, 16'h0002, 1'b1, mk(16'h0002, 16'h0, 4'b0000, 1)); collect("sbb", 0);
    send(4'd2, 16'hFFFF, 16'h0000, 1'b1, mk(16'h0000, 16'h0, 4'b0011, 1)); collect("adc_wrap", 0);
    send(4'd4, 16'hF0F0, 16'h0F0F, 1'b1, mk(16'h0000, 16'h0, 4'b0001, 1)); collect("and_zero", 0);
  endtask

  task automatic test_shift;
    send(4'd9,  16'h8001, 16'h0011, 1'b0, mk(16'hC000, 16'h0, 4'b0110, 1)); collect("sar", 0);
    send(4'd12, 16'h8000, 16'h0001, 1'b1, mk(16'h0001, 16'h0, 4'b0010, 1)); collect("rcl", 0);
    send(4'd7,  16'h8234, 16'h0010, 1'b0, mk(16'h8234, 16'h0, 4'b0100, 1)); collect("shl_n0", 0);
    send(4'd10, 16'h8001, 16'h0000, 1'b1, mk(16'h8001, 16'h0, 4'b0100, 1)); collect("rol_n0", 0);
    send(4'd11, 16'h0001, 16'h0001, 1'b0, mk(16'h8000, 16'h0, 4'b0110, 1)); collect("ror1", 0);
  endtask

  task automatic test_muldiv;
    send(4'd13, 16'hFFFF, 16'hFFFF, 1'b0, mk(16'h0001, 16'hFFFE, 4'b1010, W + 1)); collect("mul_max", 1);
    send(4'd14, 16'h0064, 16'h0007, 1'b0, mk(16'h000E, 16'h0002, 4'b0000, W + 1)); collect("divu", 1);
    send(4'd15, 16'h0064, 16'h0007, 1'b0, mk(16'h0002, 16'h0002, 4'b0000, W + 1)); collect("remu", 0);
    send(4'd14, 16'h1234, 16'h0000, 1'b0, mk(16'hFFFF, 16'h1234, 4'b1100, W + 1)); collect("divu_zero", 1);
    // Outputs hold with start low while inputs move.
    repeat (3) begin
      a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
      @(negedge clk);
    end
    checks++;
    if ({done, result, result_hi} !== {1'b0, 16'hFFFF, 16'h1234}) begin
      errors++; $display("FAIL hold: got %b/%h/%h expected 0/ffff/1234", done, result, result_hi);
    end
  endtask

  task automatic test_back_to_back;
    send(4'd0, 16'h0001, 16'h0002, 1'b0, mk(16'h0003, 16'h0, 4'b0000, 1)); collect("b2b_add", 0);
    send(4'd13, 16'h0100, 16'h0100, 1'b0, mk(16'h0000, 16'h0001, 4'b1011, W + 1)); collect("b2b_mul", 0);
    send(4'd6, 16'hAAAA, 16'hFFFF, 1'b0, mk(16'h5555, 16'h0, 4'b0000, 1)); collect("b2b_xor", 0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b no extra done: got %b expected 0", done); end
  endtask

  task automatic test_random;
    logic [3:0] o;
    logic [W-1:0] x, y;
    logic ci;
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15));
      x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom);
      if (o >= 4'd14 && (i % 4) == 0) y = '0;
      if (o >= 4'd7 && o <= 4'd12 && (i % 5) == 0) y[3:0] = 4'd0;
      send(o, x, y, ci, model(o, x, y, ci));
      collect($sformatf("rand%0d_op%0d", i, o), (i % 3) == 0);
    end
  endtask

  task automatic test_abort;
    int seen;
    send(4'd14, 16'h0064, 16'h0007, 1'b0, mk(16'h0, 16'h0, 4'h0, 0));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort busy/done: got %b expected 00", {busy, done}); end
    checks++;
    if ({result, result_hi, flags_out} !== 36'd0) begin
      errors++; $display("FAIL abort outputs: got %h/%h/%b expected zeros", result, result_hi, flags_out);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort stray done: got %0d pulses expected 0", seen); end
    send(4'd0, 16'h1000, 16'h2000, 1'b0, mk(16'h3000, 16'h0, 4'b0000, 1)); collect("abort_then_add", 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; carry_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_shift();
    test_muldiv();
    test_back_to_back();
    test_random();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 WIDTH, 16, datapath width in bits; legal values 8, 16, 32.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request; op, a, b and carry_in are sampled when start=1 and busy=0.
REQ-005 op  in  4  operation: 0 ADD, 1 SUB, 2 ADC, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR, 9 SAR, 10 ROL, 11 ROR, 12 RCL, 13 MUL, 14 DIVU, 15 REMU.
REQ-006 a  in  WIDTH  first operand (rD side).
REQ-007 b  in  WIDTH  second operand (rS or immediate, muxed upstream).
REQ-008 carry_in  in  1  incoming carry flag for ADC, SBB and RCL.
REQ-009 busy  out  1  multi-cycle operation in progress.
REQ-010 done  out  1  one-cycle pulse: result and flags_out are valid.
REQ-011 result  out  WIDTH  primary result.
REQ-012 result_hi  out  WIDTH  MUL high half; REMU/DIVU remainder; 0 otherwise.
REQ-013 flags_out  out  4  {V,S,C,Z} = bits 3..0.

Function
REQ-014 FSM states: IDLE, MUL, DIV; no other states.
REQ-015 Single-cycle ops (0-12): registered at the accepting edge; done=1 for the next cycle only; state stays IDLE.
REQ-016 MUL/DIVU/REMU: accepting edge enters MUL or DIV, busy=1; exactly WIDTH iteration cycles (shift-add / restoring shift-subtract, one bit per cycle).
REQ-017 Multi-cycle completion: result, result_hi and flags written on the WIDTH-th iteration edge, same edge returns to IDLE; busy=0 and done=1 for the following cycle.
REQ-018 start while busy=1 is ignored; no queuing.
REQ-019 start in the done cycle is accepted (back-to-back throughput).
REQ-020 result, result_hi and flags_out hold their values until the next completion.
REQ-021 ADD/ADC: result = a+b(+carry_in) mod 2^WIDTH; C = carry out of bit WIDTH-1.
REQ-022 SUB/SBB: result = a-b(-carry_in) mod 2^WIDTH; C = borrow (1 when unsigned a < b(+carry_in)).
REQ-023 V (ops 0-3): signed overflow (ADD/ADC: a,b same sign, result sign differs; SUB/SBB: a,b differ in sign, result sign differs from a).
REQ-024 Logic ops (4-6): C=0, V=0.
REQ-025 Shifts/rotates: amount n = b[log2(WIDTH)-1:0]; upper bits of b ignored.
REQ-026 SHL/SHR/SAR: C = last bit shifted out; SAR sign-fills; V=0; n=0 gives result=a, C=0.
REQ-027 ROL/ROR: rotate by n within WIDTH bits; C = bit last rotated across the boundary (0 if n=0); V=0.
REQ-028 RCL: rotate the WIDTH+1-bit value {carry_in,a} left by n; C = new carry bit; V=0.
REQ-029 MUL: unsigned, {result_hi,result} = a*b; C = V = (result_hi != 0).
REQ-030 DIVU/REMU: unsigned; DIVU result = quotient, REMU result = remainder; result_hi = remainder for both; C=0, V=0.
REQ-031 Divide by zero: takes the full WIDTH cycles; quotient all ones, remainder = a, V=1.
REQ-032 All ops: Z = (result == 0); S = result[WIDTH-1].
REQ-033 Operands of a multi-cycle op are captured at acceptance; input changes during busy have no effect.

Reset
REQ-034 rst=1 at a rising edge forces IDLE, busy=0, done=0, result=0, result_hi=0, flags_out=0.
REQ-035 rst mid-operation aborts it: no done pulse and no output update for the aborted op.
REQ-036 rst has priority over start at the same edge.

Verification (WIDTH=16)
REQ-037 ADD a=0x7FFF b=0x0001 -> next cycle done=1, result=0x8000, flags V=1 S=1 C=0 Z=0.
REQ-038 SUB a=0x0000 b=0x0001 -> result=0xFFFF, C=1, S=1, V=0; then SBB a=0x0005 b=0x0002 carry_in=1 -> result=0x0002, C=0.
REQ-039 MUL a=0xFFFF b=0xFFFF -> busy for 16 cycles, start pulses during busy ignored; done on cycle 17; result=0x0001, result_hi=0xFFFE, C=V=1.
REQ-040 DIVU a=0x0064 b=0x0007 -> result=0x000E, result_hi=0x0002; DIVU b=0 a=0x1234 -> result=0xFFFF, result_hi=0x1234, V=1.
REQ-041 SAR a=0x8001 b=0x0011 (n=1) -> result=0xC000, C=1; RCL a=0x8000 n=1 carry_in=1 -> result=0x0001, C=1.
REQ-042 rst asserted 5 cycles into a DIVU -> no done pulse, all outputs 0, busy=0; a new ADD is accepted on the next start.
